// File: rtl/trigger_input_conditioner_pkg.sv
// Shared constants for the trigger input conditioner: default debounce length
// (5 ms at the 50 kHz system clock) and the number of conditioned channels.
package trigger_input_conditioner_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd250;
    localparam int unsigned NUM_CHANNELS            = 32'd2;

endpackage

// File: rtl/trigger_input_conditioner_debounce_channel.sv
// One conditioned pushbutton: 2-FF synchronizer, consecutive-sample debounce,
// and a registered one-clock pulse on each accepted press.
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd250
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse,
    output logic level
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: any sample matching the stable level restarts the count.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            pulse_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State registers; reset drops every output to 0 without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse = pulse_q;
    assign level = stable_q;

endmodule

// File: rtl/trigger_input_conditioner.sv
// Front end for the reaction-time benchmark: two independent debounced channels
// turning raw start/user pushbuttons into clean pulses and held levels.
module trigger_input_conditioner
    import trigger_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start_btn,
    input  logic user_btn,
    output logic start_trigger,
    output logic user_trigger,
    output logic start_level,
    output logic user_level
);

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_start (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (start_btn),
        .pulse   (start_trigger),
        .level   (start_level)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_user (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (user_btn),
        .pulse   (user_trigger),
        .level   (user_level)
    );

endmodule

// File: tb/tb_trigger_input_conditioner.sv
// Directed bench for trigger_input_conditioner with a window-based reference
// model compared every cycle, plus hand-computed literal checkpoints.
module tb_trigger_input_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_btn = 1'b0;
    logic user_btn  = 1'b0;
    logic start_trigger, user_trigger, start_level, user_level;

    int vectors     = 0;
    int miscompares = 0;
    int start_pulses = 0;
    int user_pulses  = 0;
    int pc0;
    int pc1;

    trigger_input_conditioner #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_btn     (start_btn),
        .user_btn      (user_btn),
        .start_trigger (start_trigger),
        .user_trigger  (user_trigger),
        .start_level   (start_level),
        .user_level    (user_level)
    );

    always #5 clk = ~clk;

    // Reference: a level flips once the last D synchronized samples (raw delayed
    // two edges) all disagree with it; a pulse marks a flip to 1.
    bit [63:0] hist [2];
    bit        m_level [2];
    bit        m_trig  [2];
    bit        raw     [2];
    int        ones;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                hist[ch]    = '0;
                m_level[ch] = 1'b0;
                m_trig[ch]  = 1'b0;
            end
        end else begin
            raw[0] = start_btn;
            raw[1] = user_btn;
            for (int ch = 0; ch < 2; ch++) begin
                ones = 0;
                for (int k = 1; k <= D; k++) ones += int'(hist[ch][k]);
                m_trig[ch] = 1'b0;
                if (!m_level[ch] && ones == D) begin
                    m_level[ch] = 1'b1;
                    m_trig[ch]  = 1'b1;
                end else if (m_level[ch] && ones == 0) begin
                    m_level[ch] = 1'b0;
                end
                hist[ch] = {hist[ch][62:0], raw[ch]};
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference model.
    always @(negedge clk) begin
        check("model_start_trigger", start_trigger, m_trig[0]);
        check("model_user_trigger",  user_trigger,  m_trig[1]);
        check("model_start_level",   start_level,   m_level[0]);
        check("model_user_level",    user_level,    m_level[1]);
        if (start_trigger === 1'b1) start_pulses++;
        if (user_trigger === 1'b1)  user_pulses++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(2);
        check("reset_start_level", start_level, 1'b0);
        check("reset_user_level",  user_level,  1'b0);
        check("reset_start_trig",  start_trigger, 1'b0);
        check("reset_user_trig",   user_trigger,  1'b0);
        rst = 1'b0;
        step(3);

        // 1: clean press, pulse at E+5, release seen 5 edges later
        pc0 = start_pulses;
        start_btn = 1'b1;
        step(5);
        check("t1_before", start_trigger, 1'b0);
        step(1);
        check("t1_pulse", start_trigger, 1'b1);
        check("t1_level", start_level, 1'b1);
        step(1);
        check("t1_fall", start_trigger, 1'b0);
        step(13);
        start_btn = 1'b0;
        step(5);
        check("t1_level_held", start_level, 1'b1);
        step(1);
        check("t1_level_rel", start_level, 1'b0);
        step(5);
        check_int("t1_pulse_count", start_pulses - pc0, 1);

        // 2: bounce then hold
        pc0 = user_pulses;
        user_btn = 1'b1; step(1);
        user_btn = 1'b0; step(1);
        user_btn = 1'b1; step(1);
        user_btn = 1'b0; step(1);
        user_btn = 1'b1;
        step(5);
        check("t2_before", user_trigger, 1'b0);
        step(1);
        check("t2_pulse", user_trigger, 1'b1);
        step(10);
        check_int("t2_pulse_count", user_pulses - pc0, 1);
        user_btn = 1'b0;
        step(8);

        // 3: glitch shorter than the debounce window
        pc0 = start_pulses;
        start_btn = 1'b1;
        step(3);
        start_btn = 1'b0;
        step(8);
        check("t3_level", start_level, 1'b0);
        check_int("t3_pulse_count", start_pulses - pc0, 0);

        // 4: long hold, release, re-press
        pc0 = start_pulses;
        start_btn = 1'b1;
        step(100);
        start_btn = 1'b0;
        step(10);
        check_int("t4_after_release", start_pulses - pc0, 1);
        start_btn = 1'b1;
        step(10);
        start_btn = 1'b0;
        step(10);
        check_int("t4_pulse_count", start_pulses - pc0, 2);

        // 5: simultaneous presses
        start_btn = 1'b1;
        user_btn  = 1'b1;
        step(6);
        check("t5_start", start_trigger, 1'b1);
        check("t5_user",  user_trigger,  1'b1);
        step(10);
        start_btn = 1'b0;
        user_btn  = 1'b0;
        step(8);

        // 6: reset during a press, buttons held through reset
        user_btn = 1'b1;
        step(10);
        check("t6_user_level_pre", user_level, 1'b1);
        start_btn = 1'b1;
        step(2);
        #2 rst = 1'b1;
        #1;
        check("t6_async_user_level", user_level, 1'b0);
        check("t6_async_start_level", start_level, 1'b0);
        step(2);
        rst = 1'b0;
        pc0 = start_pulses;
        pc1 = user_pulses;
        step(5);
        check("t6_before", start_trigger, 1'b0);
        step(1);
        check("t6_start_pulse", start_trigger, 1'b1);
        check("t6_user_pulse",  user_trigger,  1'b1);
        step(10);
        check_int("t6_start_count", start_pulses - pc0, 1);
        check_int("t6_user_count",  user_pulses - pc1,  1);
        start_btn = 1'b0;
        user_btn  = 1'b0;
        step(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
